// File: rtl/signal_arbiter_engine_pkg.sv
// Shared types, action/mode encodings and the per-order decision rule for the signal arbiter engine.
package axi_stream_pkg;

    localparam logic [1:0] ACTION_HOLD = 2'b00;
    localparam logic [1:0] ACTION_BUY  = 2'b01;
    localparam logic [1:0] ACTION_SELL = 2'b10;

    localparam logic [1:0] MODE_ALWAYS_BUY  = 2'b00;
    localparam logic [1:0] MODE_QTY_THRESH  = 2'b01;
    localparam logic [1:0] MODE_ALWAYS_SELL = 2'b10;
    localparam logic [1:0] MODE_HOLD        = 2'b11;

    typedef struct packed {
        logic [31:0] shares;
        logic [31:0] price;
    } parsed_add_order_t;

    typedef struct packed {
        logic        valid;
        logic [1:0]  action;
        logic [15:0] confidence;
        logic [31:0] price;
        logic [31:0] quantity;
    } trade_signal_t;

    function automatic logic [1:0] decide_action(input logic [1:0] mode,
                                                 input logic [31:0] shares,
                                                 input logic [31:0] thresh);
        logic [1:0] act;
        act = ACTION_HOLD;
        case (mode)
            MODE_ALWAYS_BUY:  act = ACTION_BUY;
            MODE_QTY_THRESH:  act = (shares >= thresh) ? ACTION_BUY : ACTION_HOLD;
            MODE_ALWAYS_SELL: act = ACTION_SELL;
            default:          act = ACTION_HOLD;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/signal_arbiter_engine_if.sv
// Order-input and trade-signal-output handshake bundle for the signal arbiter engine.
interface signal_arbiter_engine_if
    import axi_stream_pkg::*;
#(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]             in_valid;
    parsed_add_order_t [NUM_CH-1:0] in_order;
    logic [NUM_CH-1:0]             in_ready;
    logic                          m_valid;
    trade_signal_t                 m_signal;
    logic                          m_ready;

    modport slave  (input  in_valid, in_order, m_ready,
                    output in_ready, m_valid, m_signal);
    modport master (output in_valid, in_order, m_ready,
                    input  in_ready, m_valid, m_signal);
endinterface

// File: rtl/signal_arbiter_engine_sig_fifo.sv
// First-word-fall-through FIFO; o_data shows the head entry combinationally while not empty.
module sig_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_wr_en;
    logic             w_rd_en;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_wr_en = i_push && !o_full && !rst;
    assign w_rd_en = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + 1'b1;
            if (w_rd_en) r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/signal_arbiter_engine.sv
// Round-robin arbiter over parsed-order channels feeding a trade-signal FIFO.
// Define SIG_ENGINE_STATS_EN to build the total_signals / stall_cycles counters.
module signal_arbiter_engine
    import axi_stream_pkg::*;
#(
    parameter int          NUM_CH     = 2,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] CONF_MAX   = 16'h7FFF
) (
    input  logic                     clk,
    input  logic                     rst,
    signal_arbiter_engine_if.slave   bus,
    input  logic [1:0]               mode,
    input  logic [31:0]              qty_thresh,
    output logic [63:0]              total_signals,
    output logic [63:0]              stall_cycles
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [IDX_W-1:0]  r_last;
    logic [IDX_W-1:0]  w_cand;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic              w_gnt_vld;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    parsed_add_order_t w_order;
    trade_signal_t     w_push_data;
    logic [$bits(trade_signal_t)-1:0] w_head;

    // Scan channels starting just after the last-served one, wrapping around.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_cand = IDX_W'((int'(r_last) + k) % NUM_CH);
            if (!w_gnt_vld && bus.in_valid[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    // Full blocks acceptance even when a pop frees a slot this same cycle.
    always_comb begin
        bus.in_ready = '0;
        if (w_gnt_vld && !w_full && !rst) bus.in_ready[w_gnt_idx] = 1'b1;
    end

    assign w_push  = |(bus.in_valid & bus.in_ready);
    assign w_pop   = bus.m_valid && bus.m_ready;
    assign w_order = bus.in_order[w_gnt_idx];

    always_comb begin
        w_push_data          = '0;
        w_push_data.valid    = 1'b1;
        w_push_data.action   = decide_action(mode, w_order.shares, qty_thresh);
        w_push_data.confidence = (w_push_data.action == ACTION_HOLD) ? 16'h0000 : CONF_MAX;
        w_push_data.price    = w_order.price;
        w_push_data.quantity = w_order.shares;
    end

    always_ff @(posedge clk) begin
        if (rst)         r_last <= IDX_W'(NUM_CH - 1);
        else if (w_push) r_last <= w_gnt_idx;
    end

    sig_fifo #(
        .WIDTH ($bits(trade_signal_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.m_valid  = !w_empty;
    assign bus.m_signal = w_empty ? '0 : trade_signal_t'(w_head);

`ifdef SIG_ENGINE_STATS_EN
    logic [63:0] r_total;
    logic [63:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_total <= '0;
            r_stall <= '0;
        end else begin
            if (w_pop)                          r_total <= r_total + 64'd1;
            if (bus.m_valid && !bus.m_ready)    r_stall <= r_stall + 64'd1;
        end
    end

    assign total_signals = r_total;
    assign stall_cycles  = r_stall;
`else
    assign total_signals = '0;
    assign stall_cycles  = '0;
`endif

endmodule

// File: tb/tb_signal_arbiter_engine.sv
// Randomized and directed checks of signal_arbiter_engine against a queue-based reference model.
module tb_signal_arbiter_engine;
    import axi_stream_pkg::*;

    localparam int          NCH  = 2;
    localparam int          DEP  = 4;
    localparam logic [15:0] CONF = 16'h7FFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [31:0] qty_thresh;
    logic [63:0] total_signals;
    logic [63:0] stall_cycles;

    signal_arbiter_engine_if #(.NUM_CH(NCH)) bus();

    signal_arbiter_engine #(
        .NUM_CH     (NCH),
        .FIFO_DEPTH (DEP),
        .CONF_MAX   (CONF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .mode          (mode),
        .qty_thresh    (qty_thresh),
        .total_signals (total_signals),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    int              n_chk;
    int              n_pass;
    trade_signal_t   exp_q[$];
    int              last_srv;
    longint unsigned m_total;
    longint unsigned m_stall;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic trade_signal_t expect_sig(input parsed_add_order_t o,
                                                 input logic [1:0] md,
                                                 input logic [31:0] th);
        trade_signal_t s;
        s          = '0;
        s.valid    = 1'b1;
        s.price    = o.price;
        s.quantity = o.shares;
        if (md == 2'b00 || (md == 2'b01 && o.shares >= th)) begin
            s.action = 2'b01; s.confidence = CONF;
        end else if (md == 2'b10) begin
            s.action = 2'b10; s.confidence = CONF;
        end else begin
            s.action = 2'b00; s.confidence = 16'h0000;
        end
        return s;
    endfunction

    task automatic rand_orders();
        for (int i = 0; i < NCH; i++) begin
            bus.in_order[i].price  = $urandom;
            bus.in_order[i].shares = $urandom_range(0, 200);
        end
    endtask

    // Called just after a negedge with inputs already applied; returns at the next negedge.
    task automatic cycle();
        int               g;
        logic [NCH-1:0]   exp_rdy;
        trade_signal_t    exp_sig;
        longint unsigned  e_tot;
        longint unsigned  e_stl;
        #1;
        g = -1;
        if (!rst && exp_q.size() < DEP)
            for (int k = 1; k <= NCH; k++)
                if (g < 0 && bus.in_valid[(last_srv + k) % NCH]) g = (last_srv + k) % NCH;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_sig = (exp_q.size() > 0) ? exp_q[0] : '0;
`ifdef SIG_ENGINE_STATS_EN
        e_tot = m_total;
        e_stl = m_stall;
`else
        e_tot = 0;
        e_stl = 0;
`endif
        chk("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
        chk("m_valid", 128'(bus.m_valid), 128'(exp_q.size() > 0));
        chk("m_signal", 128'(bus.m_signal), 128'(exp_sig));
        chk("total_signals", 128'(total_signals), 128'(e_tot));
        chk("stall_cycles", 128'(stall_cycles), 128'(e_stl));
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            last_srv = NCH - 1;
            m_total  = 0;
            m_stall  = 0;
        end else begin
            if (exp_q.size() > 0) begin
                if (bus.m_ready) begin
                    void'(exp_q.pop_front());
                    m_total++;
                end else begin
                    m_stall++;
                end
            end
            if (g >= 0) begin
                exp_q.push_back(expect_sig(bus.in_order[g], mode, qty_thresh));
                last_srv = g;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; m_total = 0; m_stall = 0; last_srv = NCH - 1;
        rst = 1'b1; mode = 2'b00; qty_thresh = '0;
        bus.in_valid = '0; bus.in_order = '0; bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held with valid inputs: nothing may be accepted.
        bus.in_valid = '1;
        cycle();
        rst = 1'b0;

        // Single Buy order on ch0.
        bus.in_valid = 2'b01; bus.m_ready = 1'b1;
        bus.in_order[0].price = 32'd1000; bus.in_order[0].shares = 32'd50;
        cycle();
        bus.in_valid = '0;
        cycle(); cycle();

        // Both channels streaming: grants alternate.
        bus.in_valid = 2'b11;
        repeat (8) begin rand_orders(); cycle(); end
        bus.in_valid = '0;
        cycle(); cycle();

        // Quantity threshold boundary.
        mode = 2'b01; qty_thresh = 32'd100; bus.in_valid = 2'b01;
        bus.in_order[0].shares = 32'd99;  cycle();
        bus.in_order[0].shares = 32'd100; cycle();
        bus.in_valid = '0;
        cycle(); cycle(); cycle();

        // Fill to full under backpressure, then a single pop with ch0 still valid.
        mode = 2'b00; bus.m_ready = 1'b0; bus.in_valid = 2'b01;
        repeat (7) begin rand_orders(); cycle(); end
        bus.m_ready = 1'b1; cycle();
        bus.m_ready = 1'b0; cycle(); cycle();
        bus.m_ready = 1'b1; bus.in_valid = '0;
        repeat (6) cycle();

        // Reset with three entries buffered.
        bus.m_ready = 1'b0; bus.in_valid = 2'b10; mode = 2'b10;
        repeat (3) begin rand_orders(); cycle(); end
        rst = 1'b1; cycle();
        rst = 1'b0; bus.in_valid = 2'b11; cycle();
        bus.m_ready = 1'b1; bus.in_valid = '0;
        repeat (3) cycle();

        // Random traffic with sporadic resets.
        repeat (800) begin
            rand_orders();
            bus.in_valid = NCH'($urandom);
            bus.m_ready  = ($urandom_range(0, 3) != 0);
            mode         = 2'($urandom);
            qty_thresh   = $urandom_range(0, 200);
            rst          = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
